// File: rtl/cpu_evolution_mem_pkg.sv
// Shared legal-value constants for the on-chip RAM slice.
package cpu_evolution_mem_pkg;

  localparam int DATA_W_LEGAL [4] = '{8, 16, 32, 64};
  localparam int MAX_READ_LATENCY = 2;

  function automatic bit data_w_ok(input int w);
    for (int i = 0; i < 4; i++) begin
      if (DATA_W_LEGAL[i] == w) return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/cpu_evolution_onchip_ram_pipe_if.sv
// Memory-mapped slave bus for the on-chip RAM; master drives requests, slave answers.
interface cpu_evolution_onchip_ram_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic                  reset_req;
  logic                  clken;
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W/8-1:0]   byteenable;
  logic [DATA_W-1:0]     writedata;
  logic                  waitrequest;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;

  modport master (
    output reset_req, clken, chipselect, read, write, address, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  reset_req, clken, chipselect, read, write, address, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/cpu_evolution_ram_core.sv
// Single-port byte-enabled RAM with registered read, no reset, no control logic.
// Latency: read data valid one cycle after re.
// Backpressure: none; caller qualifies we/re.
module cpu_evolution_ram_core
  import cpu_evolution_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    // rdata only moves on a read, so it naturally holds between reads
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/cpu_evolution_onchip_ram_pipe.sv
// On-chip RAM slave: handshake, read-valid pipeline and output register around the RAM core.
// Latency: READ_LATENCY (1 or 2) cycles from accepted read to readdatavalid.
// Backpressure: waitrequest = ~clken | reset_req; accepted reads always complete.
module cpu_evolution_onchip_ram_pipe
  import cpu_evolution_mem_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  cpu_evolution_onchip_ram_pipe_if.slave bus
);
  if (!data_w_ok(DATA_W) || READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_param
    $error("cpu_evolution_onchip_ram_pipe: unsupported DATA_W/READ_LATENCY");
  end

  logic                    wr_acc;
  logic                    rd_acc;
  logic [DATA_W-1:0]       ram_q;
  logic [DATA_W-1:0]       out_q;
  logic [READ_LATENCY-1:0] vld_pipe;

  assign bus.waitrequest = ~bus.clken | bus.reset_req;

  // Reset gates acceptance so nothing reaches the RAM while reset is held
  assign wr_acc = ~reset & bus.chipselect & bus.write & ~bus.waitrequest;
  assign rd_acc = ~reset & bus.chipselect & bus.read & ~bus.write & ~bus.waitrequest;

  cpu_evolution_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram_core (
    .clk   (clk),
    .we    (wr_acc),
    .re    (rd_acc),
    .addr  (bus.address),
    .be    (bus.byteenable),
    .wdata (bus.writedata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_acc;
      for (int i = 1; i < READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Captures the RAM word once per returned read; serves as hold value or output stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            out_q <= '0;
    else if (vld_pipe[0]) out_q <= ram_q;
  end

  assign bus.readdatavalid = vld_pipe[READ_LATENCY-1];

  if (READ_LATENCY == 2) begin : g_out_reg
    assign bus.readdata = out_q;
  end else begin : g_out_direct
    assign bus.readdata = vld_pipe[0] ? ram_q : out_q;
  end
endmodule

// File: doc/cpu_evolution_onchip_ram_pipe.md
CPU_EVOLUTION_ONCHIP_RAM_PIPE -- requirements
Module: cpu_evolution_onchip_ram_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter ADDR_W, default 10, word-address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter READ_LATENCY, default 1, cycles from read acceptance to readdatavalid; legal values 1, 2.
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port reset_req  input  1  synchronous request to quiesce; blocks new accesses.
REQ-007 SHALL have port clken  input  1  access enable; low blocks new accesses.
REQ-008 SHALL have port chipselect  input  1  slave select.
REQ-009 SHALL have port read  input  1  read request.
REQ-010 SHALL have port write  input  1  write request.
REQ-011 SHALL have port address  input  ADDR_W  word address.
REQ-012 SHALL have port byteenable  input  DATA_W/8  per-byte write enable.
REQ-013 SHALL have port writedata  input  DATA_W  write data.
REQ-014 SHALL have port waitrequest  output  1  high = request not accepted this cycle.
REQ-015 SHALL have port readdata  output  DATA_W  read data.
REQ-016 SHALL have port readdatavalid  output  1  one-cycle strobe qualifying readdata.

Function
REQ-017 SHALL drive waitrequest combinationally = ~clken | reset_req.
REQ-018 SHALL accept a write when chipselect & write & ~waitrequest; lanes with byteenable[i]=1 updated at that edge, other lanes unchanged.
REQ-019 SHALL accept a read when chipselect & read & ~write & ~waitrequest; read and write both high = write only, no readdatavalid generated.
REQ-020 SHALL assert readdatavalid exactly READ_LATENCY cycles after each accepted read, for one cycle, with readdata = word content at acceptance edge.
REQ-021 SHALL return new data for a read accepted the cycle after a write to the same address; no same-cycle read/write collision exists (REQ-019).
REQ-022 SHALL sustain one accepted access per cycle; back-to-back reads produce back-to-back readdatavalid in order.
REQ-023 SHALL hold readdata at its last valid value while readdatavalid=0.
REQ-024 SHALL keep the read pipeline advancing every cycle regardless of clken/reset_req; reads already accepted complete.
REQ-025 SHALL wrap nothing: every address in 0..2**ADDR_W-1 is valid; no error response.
REQ-026 SHALL, when READ_LATENCY=2, register RAM output once more (output register stage), no additional throughput limit.

Reset
REQ-027 SHALL, on reset assertion, immediately clear readdatavalid to 0, readdata to 0, and all in-flight read-valid pipeline bits.
REQ-028 SHALL NOT clear memory contents on reset; contents after reset are undefined until written.
REQ-029 SHALL ignore requests while reset is high; waitrequest follows REQ-017 independent of reset.
REQ-030 SHALL release reset without spurious readdatavalid in the first READ_LATENCY cycles.

Structure
REQ-031 SHALL place legal-value constants (supported DATA_W list, max READ_LATENCY=2) in shared package cpu_evolution_mem_pkg.
REQ-032 SHALL instantiate one sub-module cpu_evolution_ram_core: inferred single-port byte-enabled RAM with registered synchronous read, no reset.
REQ-033 SHALL keep handshake, valid pipeline and output register in the top module; RAM core has no control logic.

Verification (DATA_W=32, ADDR_W=10 unless stated)
REQ-034 SHALL cover: write 0xDEADBEEF @0x010 be=0xF, then read @0x010 -> readdatavalid after READ_LATENCY cycles, readdata=0xDEADBEEF, for READ_LATENCY=1 and 2.
REQ-035 SHALL cover: write 0x11223344 @0x3FF, then write 0xAABBCCDD be=0x5 @0x3FF, read -> 0x11BB33DD.
REQ-036 SHALL cover: reads @0,1,2,3 back-to-back after writes of 0xA0..0xA3 -> four consecutive readdatavalid, data 0xA0,0xA1,0xA2,0xA3 in order.
REQ-037 SHALL cover: clken=0 or reset_req=1 with write of 0x55 @0x020 -> waitrequest=1, location keeps prior value; read accepted one cycle before clken drop still returns valid data.
REQ-038 SHALL cover: read @0x005 accepted, reset asserted next cycle -> readdatavalid=0 and readdata=0 immediately, no valid strobe after reset release; previously written 0x12345678 @0x005 still reads back.
REQ-039 SHALL cover: read and write both high @0x030 with writedata 0x77 -> location becomes 0x77, no readdatavalid.
